// File: rtl/pcie_tlp_splitter_pkg.sv
// Shared types and constants for the PCIe TLP splitter.
//   - TLP command codes (MWr/MRd, 32-bit addressing)
//   - FSM state encoding
//   - egress command payload struct
//   - max-size decode helper (32 << n dwords, n clamped to 5)
package pcie_tlp_splitter_pkg;

    localparam logic [7:0]  PCIE_MWR_32B = 8'h40;
    localparam logic [7:0]  PCIE_MRD_32B = 8'h00;

    localparam int unsigned CHUNK_W      = 11;     // holds 1..1024
    localparam int unsigned DW_MAX       = 1024;   // hard cap per TLP / per 4 KB page
    localparam int unsigned MAX_SIZE_SEL = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [13:0] flags;
        logic [31:0] address;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [9:0]  dword_cnt;
    } egress_cmd_t;

    // Decode the max-size selector into a dword limit.
    function automatic logic [CHUNK_W-1:0] max_size_dw(input logic [2:0] n);
        logic [2:0] sel;
        sel = (n > 3'(MAX_SIZE_SEL)) ? 3'(MAX_SIZE_SEL) : n;
        return CHUNK_W'(32) << sel;
    endfunction

endpackage

// File: rtl/pcie_chunk_calc.sv
// Combinational chunk sizing: min(remaining, max size, dwords left in 4 KB page).
// Ports:
//   i_remaining   dwords still to issue
//   i_address_dw  address bits [11:2] (dword offset inside the 4 KB page)
//   i_max_size    size selector (32 << n dwords, 6/7 clamp to 1024)
//   o_chunk_c     chunk size in dwords, 1..1024 when i_remaining != 0
module pcie_chunk_calc
    import pcie_tlp_splitter_pkg::*;
(
    input  logic [23:0]        i_remaining,
    input  logic [9:0]         i_address_dw,
    input  logic [2:0]         i_max_size,
    output logic [CHUNK_W-1:0] o_chunk_c
);

    logic [CHUNK_W-1:0] w_limit;
    logic [CHUNK_W-1:0] w_boundary;
    logic [CHUNK_W-1:0] w_cap;

    always_comb begin
        w_limit    = max_size_dw(i_max_size);
        w_boundary = CHUNK_W'(DW_MAX) - {1'b0, i_address_dw};
        w_cap      = (w_limit < w_boundary) ? w_limit : w_boundary;
        o_chunk_c  = (i_remaining < 24'(w_cap)) ? CHUNK_W'(i_remaining) : w_cap;
    end

endmodule

// File: rtl/pcie_tlp_splitter.sv
// Splits one host-bound MWr/MRd transfer into TLPs clipped to max size and
// 4 KB boundaries, sequencing the egress engine and the upstream data FIFO.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_enable / o_finished/o_busy  transfer handshake
//   i_command..i_tag_base         transfer description (sampled in IDLE)
//   o_chunk_count                 TLPs issued so far
//   o_egress_*, i_egress_finished egress-engine command bus
//   o_fifo_*/i_fifo_*             FIFO face presented to the egress engine
//   i_src_*/o_src_*               upstream data FIFO
module pcie_tlp_splitter
    import pcie_tlp_splitter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    output logic        o_finished,
    output logic        o_busy,
    input  logic [7:0]  i_command,
    input  logic [13:0] i_flags,
    input  logic [31:0] i_address,
    input  logic [23:0] i_dword_total,
    input  logic [2:0]  i_max_size,
    input  logic [15:0] i_requester_id,
    input  logic [7:0]  i_tag_base,
    output logic [15:0] o_chunk_count,
    output logic        o_egress_enable,
    output logic [7:0]  o_egress_command,
    output logic [13:0] o_egress_flags,
    output logic [31:0] o_egress_address,
    output logic [15:0] o_egress_requester_id,
    output logic [7:0]  o_egress_tag,
    output logic [9:0]  o_egress_dword_cnt,
    input  logic        i_egress_finished,
    output logic        o_fifo_rdy,
    input  logic        i_fifo_act,
    output logic [23:0] o_fifo_size,
    output logic [31:0] o_fifo_data,
    input  logic        i_fifo_stb,
    input  logic        i_src_rdy,
    output logic        o_src_act,
    input  logic [23:0] i_src_count,
    input  logic [31:0] i_src_data,
    output logic        o_src_stb
);

    state_t             r_state,       w_state_nxt;
    egress_cmd_t        r_eg,          w_eg_nxt;
    logic               r_is_read,     w_is_read_nxt;
    logic [23:0]        r_remaining,   w_remaining_nxt;
    logic [CHUNK_W-1:0] r_chunk,       w_chunk_nxt;
    logic [2:0]         r_max_size,    w_max_size_nxt;
    logic               r_egress_en,   w_egress_en_nxt;
    logic               r_fifo_rdy,    w_fifo_rdy_nxt;
    logic               r_src_act,     w_src_act_nxt;
    logic [23:0]        r_fifo_size,   w_fifo_size_nxt;
    logic [15:0]        r_chunk_count, w_chunk_count_nxt;
    logic               r_finished,    w_finished_nxt;
    logic               r_busy,        w_busy_nxt;
    logic [CHUNK_W-1:0] w_chunk_c;

    pcie_chunk_calc u_chunk_calc (
        .i_remaining  (r_remaining),
        .i_address_dw (r_eg.address[11:2]),
        .i_max_size   (r_max_size),
        .o_chunk_c    (w_chunk_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_eg          <= '0;
            r_is_read     <= 1'b0;
            r_remaining   <= '0;
            r_chunk       <= '0;
            r_max_size    <= '0;
            r_egress_en   <= 1'b0;
            r_fifo_rdy    <= 1'b0;
            r_src_act     <= 1'b0;
            r_fifo_size   <= '0;
            r_chunk_count <= '0;
            r_finished    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_eg          <= w_eg_nxt;
            r_is_read     <= w_is_read_nxt;
            r_remaining   <= w_remaining_nxt;
            r_chunk       <= w_chunk_nxt;
            r_max_size    <= w_max_size_nxt;
            r_egress_en   <= w_egress_en_nxt;
            r_fifo_rdy    <= w_fifo_rdy_nxt;
            r_src_act     <= w_src_act_nxt;
            r_fifo_size   <= w_fifo_size_nxt;
            r_chunk_count <= w_chunk_count_nxt;
            r_finished    <= w_finished_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_eg_nxt          = r_eg;
        w_is_read_nxt     = r_is_read;
        w_remaining_nxt   = r_remaining;
        w_chunk_nxt       = r_chunk;
        w_max_size_nxt    = r_max_size;
        w_egress_en_nxt   = r_egress_en;
        w_fifo_rdy_nxt    = r_fifo_rdy;
        w_src_act_nxt     = r_src_act;
        w_fifo_size_nxt   = r_fifo_size;
        w_chunk_count_nxt = r_chunk_count;
        w_finished_nxt    = r_finished;
        w_busy_nxt        = r_busy;

        unique case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    // Anything that is not an MRd is issued as an MWr.
                    w_is_read_nxt         = (i_command == PCIE_MRD_32B);
                    w_eg_nxt.cmd          = (i_command == PCIE_MRD_32B) ? PCIE_MRD_32B : PCIE_MWR_32B;
                    w_eg_nxt.flags        = i_flags;
                    w_eg_nxt.address      = i_address & ~32'h3;
                    w_eg_nxt.requester_id = i_requester_id;
                    w_eg_nxt.tag          = i_tag_base;
                    w_eg_nxt.dword_cnt    = '0;
                    w_remaining_nxt       = i_dword_total;
                    w_max_size_nxt        = i_max_size;
                    w_chunk_count_nxt     = '0;
                    w_busy_nxt            = 1'b1;
                    w_state_nxt           = (i_dword_total == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                // 1024 truncates to 0 in the 10-bit TLP length field.
                w_chunk_nxt        = w_chunk_c;
                w_eg_nxt.dword_cnt = w_chunk_c[9:0];
                w_fifo_size_nxt    = 24'(w_chunk_c);
                w_state_nxt        = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_is_read) begin
                    w_egress_en_nxt = 1'b1;
                    w_state_nxt     = S_WAIT_DONE;
                end else if (i_src_rdy && (i_src_count >= 24'(r_chunk))) begin
                    w_egress_en_nxt = 1'b1;
                    w_src_act_nxt   = 1'b1;
                    w_fifo_rdy_nxt  = 1'b1;
                    w_state_nxt     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_fifo_act) begin
                    w_fifo_rdy_nxt = 1'b0;
                end
                if (i_egress_finished) begin
                    w_egress_en_nxt   = 1'b0;
                    w_src_act_nxt     = 1'b0;
                    w_fifo_rdy_nxt    = 1'b0;
                    w_eg_nxt.address  = r_eg.address + 32'({r_chunk, 2'b00});
                    w_eg_nxt.tag      = r_eg.tag + 8'd1;
                    w_remaining_nxt   = r_remaining - 24'(r_chunk);
                    w_chunk_count_nxt = r_chunk_count + 16'd1;
                    w_state_nxt       = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!i_egress_finished) begin
                    w_state_nxt = (r_remaining == '0) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                // Raise finished on the first DONE cycle; leave once enable drops.
                if (!r_finished) begin
                    w_finished_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                end else if (!i_enable) begin
                    w_finished_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_finished            = r_finished;
    assign o_busy                = r_busy;
    assign o_chunk_count         = r_chunk_count;
    assign o_egress_enable       = r_egress_en;
    assign o_egress_command      = r_eg.cmd;
    assign o_egress_flags        = r_eg.flags;
    assign o_egress_address      = r_eg.address;
    assign o_egress_requester_id = r_eg.requester_id;
    assign o_egress_tag          = r_eg.tag;
    assign o_egress_dword_cnt    = r_eg.dword_cnt;
    assign o_fifo_rdy            = r_fifo_rdy;
    assign o_fifo_size           = r_fifo_size;
    assign o_src_act             = r_src_act;

    // Data path is a straight combinational pass-through.
    assign o_fifo_data           = i_src_data;
    assign o_src_stb             = i_fifo_stb;

endmodule

// File: doc/pcie_tlp_splitter.md
# pcie_tlp_splitter

Request sequencer directly upstream of the PCIe egress engine. Takes one host-bound transfer (memory write of N dwords or memory read request of N dwords) and issues it to the egress engine as a series of TLPs. Each TLP is clipped to max payload / max read request size and never crosses a 4 KB address boundary. For writes it re-presents the upstream data FIFO so the egress engine sees each chunk as its own FIFO block; for reads it assigns incrementing tags.

## Interface
- No parameters; `PCIE_MWR_32B`/`PCIE_MRD_32B` command codes come from `pcie_defines.v`.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  start transfer (level; held until o_finished, then dropped)
- o_finished  out  1  transfer complete (level)
- o_busy  out  1  high from start until o_finished
- i_command  in  8  `PCIE_MWR_32B` or `PCIE_MRD_32B`; other values treated as MWR
- i_flags  in  14  passed to egress unchanged
- i_address  in  32  start byte address; bits [1:0] ignored (treated 0)
- i_dword_total  in  24  total dwords
- i_max_size  in  3  chunk limit 32<<n dwords (n=0..5); values 6,7 clamp to 5 (1024)
- i_requester_id  in  16  passthrough
- i_tag_base  in  8  first read tag
- o_chunk_count  out  16  TLPs issued this transfer
- o_egress_enable, o_egress_command[7:0], o_egress_flags[13:0], o_egress_address[31:0], o_egress_requester_id[15:0], o_egress_tag[7:0], o_egress_dword_cnt[9:0]  out  egress-engine command bus
- i_egress_finished  in  1  egress-engine done
- o_fifo_rdy  out  1, i_fifo_act  in  1, o_fifo_size  out  24, o_fifo_data  out  32, i_fifo_stb  in  1  FIFO face toward egress
- i_src_rdy  in  1, o_src_act  out  1, i_src_count  in  24, i_src_data  in  32, o_src_stb  out  1  upstream data FIFO

## Operation
- States: IDLE, CALC, ISSUE, WAIT_DONE, RELEASE, DONE.
- IDLE: on i_enable, latch address/total/command/tag, clear o_chunk_count, go to CALC; o_busy=1. If i_dword_total==0, go straight to DONE.
- CALC: chunk = min(remaining, 32<<n, 1024 − addr[11:2]). Register it into o_egress_dword_cnt (10 bits; a value of 1024 encodes as 0) and o_fifo_size (24 bits, zero-extended, 1024 literal). Then go to ISSUE.
- ISSUE:
  - MRD: assert o_egress_enable, go to WAIT_DONE.
  - MWR: wait for i_src_rdy && i_src_count ≥ chunk, then assert o_src_act, o_fifo_rdy, o_egress_enable, go to WAIT_DONE.
- WAIT_DONE: o_fifo_rdy drops once i_fifo_act seen high. On i_egress_finished: drop o_egress_enable, o_src_act; address += chunk*4 (32-bit wrap), remaining −= chunk, tag += 1 (8-bit wrap), o_chunk_count += 1; go to RELEASE.
- RELEASE: wait i_egress_finished==0. Then go to DONE if remaining==0, else CALC.
- DONE: o_finished=1, o_busy=0; on !i_enable clear o_finished and return to IDLE.
- Data path combinational: o_fifo_data=i_src_data, o_src_stb=i_fifo_stb.
- i_enable dropped mid-transfer: ignored until DONE. The current chunk always completes; the transfer completes.
- Inputs other than i_enable are sampled only in IDLE.

## Timing
- All outputs reset to 0, state=IDLE.
- i_enable sampled high at edge k → o_egress_enable high after edge k+2 (MRD, or MWR with source ready).
- Inter-chunk gap: i_egress_finished low → next o_egress_enable high 2 cycles later (RELEASE→CALC→ISSUE).
- o_finished rises one cycle after last RELEASE exit; falls one cycle after i_enable low.
- o_egress_* command fields stable whenever o_egress_enable=1.
- Reset assertion mid-transfer: all outputs 0 immediately (async). The egress engine sees enable drop; no resume after reset.

## Structure
- Shared package/defines: state encodings, MRD/MWR codes (existing `pcie_defines.v`), max-size decode constant (1024-dword cap).
- One natural sub-module: `pcie_chunk_calc` (combinational min of remaining / max size / 4 KB boundary), registered by the parent.

## Test plan
- MWR addr 0x1000, 16 dwords, n=0 → one TLP, dword_cnt 16, fifo_size 16, o_chunk_count 1, o_finished.
- MWR addr 0x0FF0, 10 dwords, n=5 → two TLPs: 4 dwords @0x0FF0, 6 dwords @0x1000.
- MRD addr 0x0, 200 dwords, n=1 (64), tag_base 0xFE → 64/64/64/8 dwords at 0x0/0x100/0x200/0x300, tags FE,FF,00,01.
- MRD 1024 dwords n=7 aligned 0x2000 → single TLP, o_egress_dword_cnt 0, fifo_size 1024.
- Zero length → o_finished at edge k+1, o_egress_enable never asserted.
- MWR with i_src_count < chunk for 20 cycles → ISSUE holds, no enable; rst_n low during WAIT_DONE → all outputs 0 same cycle.
